udp_checksum_fifo_writer: RTL and testbench
===========================================

# udp_checksum_fifo_writer

Write-side producer for the UDP checksum DRM FIFO: accepts a 32-bit payload stream with valid/ready/last/keep and pushes every beat into the FIFO write port through the `wr_en`/`wr_vld` handshake. While writing, it accumulates the 16-bit one's-complement Internet checksum of the frame, seeded with a pseudo-header partial sum. At frame end it presents the final UDP checksum and the beat count to the header builder. It sits in the `wr_clk` domain, upstream of the FIFO; the prefetch read side drains the FIFO independently.

## Interface
- c_WR_DATA_WIDTH, 32, payload/FIFO word width; fixed at 32 (two 16-bit halves)
- c_LEN_WIDTH, 16, width of beat counter `frame_beats`
- wr_clk  in  1  sole clock
- wr_rst  in  1  reset; **synchronous, active-high**
- in_data  in  32  payload beat; byte [31:24] is first on the wire
- in_keep  in  4  byte valid mask, last beat only; bit 3 = [31:24]; contiguous from bit 3 down
- in_last  in  1  final beat of frame
- in_valid  in  1  beat valid
- in_ready  out  1  beat accepted when `in_valid & in_ready`
- csum_init  in  16  pseudo-header partial sum, sampled on the first beat of a frame
- wr_data  out  32  FIFO write data (= `in_data`, unmodified)
- wr_en  out  1  FIFO write strobe
- wr_vld  in  1  FIFO not full
- csum_out  out  16  final UDP checksum
- csum_vld  out  1  one-cycle strobe, `csum_out`/`frame_beats` valid
- frame_beats  out  c_LEN_WIDTH  beats in the completed frame

## Operation
- States: ACC, FOLD1, FOLD2, DONE. Reset → ACC.
- `in_ready = wr_vld & (state==ACC) & ~wr_rst`; `wr_en = in_valid & in_ready`; `wr_data = in_data`. Combinational pass-through, zero latency.
- Per accepted beat: `hi = d[31:16]`, `lo = d[15:0]` after masking. On non-last beats, `in_keep` is ignored (all bytes count). On the last beat, bytes with keep=0 are zeroed in the sum only; FIFO data is not altered.
- Accumulator `acc` is 18 bits. `base` = `csum_init` on the first beat of a frame, otherwise `acc`. `acc <= base[15:0] + base[17:16] + hi + lo`. End-around carry is folded every beat, so the accumulator cannot overflow (max 0x30000).
- First-beat flag: set at reset and after DONE; cleared on any accepted non-last beat.
- Beat counter: cleared at frame start, +1 per accepted beat, saturates at all-ones. It is copied to `frame_beats` at DONE.
- ACC→FOLD1 on an accepted beat with `in_last`.
- FOLD1: `acc <= acc[15:0] + acc[17:16]`. FOLD2: same operation, after which the result is ≤ 0xFFFF.
- FOLD2→DONE: `csum_out <= ~acc[15:0]`, except that a result of 0x0000 is transmitted as 0xFFFF (UDP rule); `csum_vld <= 1`.
- DONE→ACC unconditionally; `csum_vld` drops. `csum_out`/`frame_beats` hold until the next DONE.
- Single-beat frame: the first beat is also the last; the seed and the last-beat mask apply together.
- `wr_vld` low in ACC: `in_ready` is low, no write, the accumulator holds, and the frame continues when `wr_vld` returns.
- `in_valid` low mid-frame: hold state, no timeout.

## Timing
- Reset values: `in_ready` 0 during reset, `wr_en` 0, `csum_vld` 0, `csum_out` 0x0000, `frame_beats` 0, `acc` 0, first-beat flag 1.
- Reset mid-frame: the frame is abandoned, no `csum_vld` is produced, and beats already written stay in the FIFO (the read side owns flushing).
- If the last beat is accepted in cycle T:
  - FOLD1 in T+1, FOLD2 in T+2.
  - `csum_vld` is high in T+3 only.
  - `in_ready` is low T+1..T+3.
  - The first beat of the next frame can be accepted at T+4.
- Throughput: one beat per cycle within a frame; 3-cycle gap between frames.

## Test plan
- Seed 0, single beat 0x45000073 keep 1111 last → one `wr_en` with data 0x45000073; at T+3 `csum_vld`=1, `csum_out`=0xBA8C, `frame_beats`=1.
- Seed 0, beats 0xFFFFFFFF then 0x00000001 (last, keep 1111) → `acc` 0x1FFFE then 0x10000, then 1 after folding; `csum_out`=0xFFFE, `frame_beats`=2.
- Seed 0, single beat 0xFFFF0000 → sum 0xFFFF, complement 0x0000, output must be `csum_out`=0xFFFF.
- Seed 0x0011, single beat 0x12345678 keep 1100 → sum 0x1245, `csum_out`=0xEDBA; `wr_data` still 0x12345678.
- Three-beat frame with `wr_vld` low for 5 cycles after beat 1 → `in_ready`=0 and no `wr_en` during the stall; the checksum matches the unstalled run; exactly 3 writes.
- `wr_rst` pulsed after beat 2 of a 4-beat frame, then a fresh 1-beat frame 0x45000073 → no `csum_vld` for the aborted frame; the fresh frame gives 0xBA8C and `frame_beats`=1.

Source files
------------

// File: rtl/udp_checksum_fifo_writer.sv
// udp_checksum_fifo_writer
//
// Write-side producer for the UDP checksum FIFO. Payload beats are passed
// straight through to the FIFO write port with zero latency. While each beat
// is written, a 16-bit one's-complement checksum is accumulated. The sum is
// seeded with the pseudo-header partial sum that is presented on the first
// beat of the frame. After the last beat there are two fold cycles. One cycle
// after that, the final UDP checksum and the beat count are presented for a
// single cycle.
//
// Ports
//   wr_clk       sole clock
//   wr_rst       synchronous active-high reset
//   in_data      payload beat, byte [31:24] first on the wire
//   in_keep      byte mask, honoured on the last beat only (bit 3 = [31:24])
//   in_last      final beat of the frame
//   in_valid     beat valid
//   in_ready     beat accepted when in_valid & in_ready
//   csum_init    pseudo-header partial sum, sampled on a frame's first beat
//   wr_data      FIFO write data (in_data, unmodified)
//   wr_en        FIFO write strobe
//   wr_vld       FIFO not full
//   csum_out     final UDP checksum (0x0000 is sent as 0xFFFF)
//   csum_vld     one-cycle strobe qualifying csum_out / frame_beats
//   frame_beats  number of beats in the completed frame (saturating)

module udp_checksum_fifo_writer #(
  parameter int c_WR_DATA_WIDTH = 32,  // fixed at 32: two 16-bit halves per beat
  parameter int c_LEN_WIDTH     = 16
) (
  input  logic                       wr_clk,
  input  logic                       wr_rst,
  input  logic [c_WR_DATA_WIDTH-1:0] in_data,
  input  logic [3:0]                 in_keep,
  input  logic                       in_last,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [15:0]                csum_init,
  output logic [c_WR_DATA_WIDTH-1:0] wr_data,
  output logic                       wr_en,
  input  logic                       wr_vld,
  output logic [15:0]                csum_out,
  output logic                       csum_vld,
  output logic [c_LEN_WIDTH-1:0]     frame_beats
);

  typedef enum logic [1:0] {
    ST_ACC   = 2'd0,
    ST_FOLD1 = 2'd1,
    ST_FOLD2 = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                   state_reg;
  state_t                   state_next;

  logic [17:0]              acc_reg;
  logic                     first_reg;
  logic [c_LEN_WIDTH-1:0]   beat_cnt_reg;
  logic [15:0]              csum_out_reg;
  logic                     csum_vld_reg;
  logic [c_LEN_WIDTH-1:0]   frame_beats_reg;

  logic                     accept;
  logic [3:0]               byte_en;
  logic [31:0]              beat_masked;
  logic [17:0]              base;
  logic [17:0]              acc_sum;
  logic [17:0]              acc_fold;
  logic [15:0]              csum_cmpl;
  logic [15:0]              csum_final;
  logic [c_LEN_WIDTH-1:0]   beat_cnt_next;

  // Handshake and FIFO pass-through are purely combinational.
  assign in_ready = wr_vld & (state_reg == ST_ACC) & ~wr_rst;
  assign accept   = in_valid & in_ready;
  assign wr_en    = accept;
  assign wr_data  = in_data;

  // Only the last beat of a frame can be partial. Dropped bytes are zeroed
  // for the checksum only. The FIFO still receives the beat exactly as it
  // was presented.
  assign byte_en = in_last ? in_keep : 4'hF;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_byte_mask
      assign beat_masked[gi*8 +: 8] = in_data[gi*8 +: 8] & {8{byte_en[gi]}};
    end
  endgenerate

  // Accumulate with end-around carry on every beat. The 18-bit accumulator
  // is therefore bounded and can never wrap, whatever the frame length.
  always_comb begin
    base    = first_reg ? {2'b00, csum_init} : acc_reg;
    acc_sum = {2'b00, base[15:0]} + {16'd0, base[17:16]}
            + {2'b00, beat_masked[31:16]} + {2'b00, beat_masked[15:0]};
  end

  // Fold step used in both fold states. After the second fold the upper
  // bits are guaranteed to be zero.
  assign acc_fold = {2'b00, acc_reg[15:0]} + {16'd0, acc_reg[17:16]};

  // The UDP checksum value 0x0000 means "no checksum". A computed zero is
  // therefore transmitted as its one's-complement twin, 0xFFFF.
  assign csum_cmpl  = ~acc_fold[15:0];
  assign csum_final = (csum_cmpl == 16'h0000) ? 16'hFFFF : csum_cmpl;

  // Beat counter restarts at 1 on a frame's first beat and sticks at all-ones.
  always_comb begin
    beat_cnt_next = beat_cnt_reg;
    if (first_reg) begin
      beat_cnt_next = c_LEN_WIDTH'(1);
    end else if (beat_cnt_reg != {c_LEN_WIDTH{1'b1}}) begin
      beat_cnt_next = beat_cnt_reg + c_LEN_WIDTH'(1);
    end
  end

  // FSM state register.
  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      state_reg <= ST_ACC;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_ACC: begin
        if (accept && in_last) begin
          state_next = ST_FOLD1;
        end
      end
      ST_FOLD1: state_next = ST_FOLD2;
      ST_FOLD2: state_next = ST_DONE;
      ST_DONE:  state_next = ST_ACC;
      default:  state_next = ST_ACC;
    endcase
  end

  // Datapath: accumulator, first-beat flag, beat counter and result registers.
  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      acc_reg         <= '0;
      first_reg       <= 1'b1;
      beat_cnt_reg    <= '0;
      csum_out_reg    <= '0;
      csum_vld_reg    <= 1'b0;
      frame_beats_reg <= '0;
    end else begin
      csum_vld_reg <= 1'b0;
      case (state_reg)
        ST_ACC: begin
          if (accept) begin
            acc_reg      <= acc_sum;
            beat_cnt_reg <= beat_cnt_next;
            // A single-beat frame keeps the flag set. DONE re-arms it anyway.
            if (!in_last) begin
              first_reg <= 1'b0;
            end
          end
        end
        ST_FOLD1: begin
          acc_reg <= acc_fold;
        end
        ST_FOLD2: begin
          // Results are captured from the second fold's value, so they
          // become visible together with the DONE state.
          acc_reg         <= acc_fold;
          csum_out_reg    <= csum_final;
          csum_vld_reg    <= 1'b1;
          frame_beats_reg <= beat_cnt_reg;
        end
        ST_DONE: begin
          first_reg <= 1'b1;
        end
        default: begin
          first_reg <= 1'b1;
        end
      endcase
    end
  end

  assign csum_out    = csum_out_reg;
  assign csum_vld    = csum_vld_reg;
  assign frame_beats = frame_beats_reg;

endmodule

// File: tb/tb_udp_checksum_fifo_writer.sv
// Self-checking bench for udp_checksum_fifo_writer.
// A driver issues frames and pushes the expected FIFO writes and checksum
// results into queues. A monitor sampling on the falling edge pops those
// queues and compares them with what the DUT presents.

module tb_udp_checksum_fifo_writer;

  logic        wr_clk;
  logic        wr_rst;
  logic [31:0] in_data;
  logic [3:0]  in_keep;
  logic        in_last;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] csum_init;
  logic [31:0] wr_data;
  logic        wr_en;
  logic        wr_vld;
  logic [15:0] csum_out;
  logic        csum_vld;
  logic [15:0] frame_beats;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] wr_q[$];
  logic [15:0] csum_q[$];
  int          len_q[$];

  logic [31:0] fbeat[16];
  int          stall_cnt  = 0;
  bit          rnd_vld    = 0;
  bit          rnd_gaps   = 0;
  bit          last_ready = 0;
  bit          abort_all  = 0;

  udp_checksum_fifo_writer #(
    .c_WR_DATA_WIDTH(32),
    .c_LEN_WIDTH(16)
  ) dut (
    .wr_clk(wr_clk),
    .wr_rst(wr_rst),
    .in_data(in_data),
    .in_keep(in_keep),
    .in_last(in_last),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .csum_init(csum_init),
    .wr_data(wr_data),
    .wr_en(wr_en),
    .wr_vld(wr_vld),
    .csum_out(csum_out),
    .csum_vld(csum_vld),
    .frame_beats(frame_beats)
  );

  initial begin
    wr_clk = 1'b0;
    forever #5 wr_clk = ~wr_clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference checksum: add everything as one wide integer, then fold and
  // complement. No per-beat carry handling is needed at this level.
  function automatic logic [15:0] ref_csum(input logic [15:0] seed, input int n,
                                           input logic [3:0] lkeep);
    longint unsigned s;
    logic [31:0]     w;
    logic [15:0]     r;
    s = 64'(seed);
    for (int i = 0; i < n; i++) begin
      w = fbeat[i];
      if (i == n - 1) begin
        for (int b = 0; b < 4; b++) begin
          if (!lkeep[b]) w[b*8 +: 8] = 8'h00;
        end
      end
      s += 64'(w[31:16]);
      s += 64'(w[15:0]);
    end
    while (s > 64'hFFFF) s = (s & 64'hFFFF) + (s >> 16);
    r = ~s[15:0];
    return (r == 16'h0000) ? 16'hFFFF : r;
  endfunction

  task automatic cycle();
    @(negedge wr_clk);
    last_ready = in_ready;
    @(posedge wr_clk);
    #1;
  endtask

  task automatic set_vld();
    if (stall_cnt > 0) begin
      wr_vld = 1'b0;
      stall_cnt--;
    end else begin
      wr_vld = rnd_vld ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  endtask

  // n beats from fbeat[]. stall_after=k (k>0) drops wr_vld for 5 cycles
  // after beat k. abort_after=k (k>0) resets the DUT after beat k instead of
  // finishing. exp_csum >= 0 gives the expected checksum directly;
  // otherwise the reference model provides it.
  task automatic drive_frame(input logic [15:0] seed, input int n, input logic [3:0] lkeep,
                             input int stall_after, input int abort_after, input int exp_csum);
    int c;
    int gap;
    if (abort_all) return;
    for (int i = 0; i < n; i++) begin
      if (abort_after == 0 || i < abort_after) wr_q.push_back(fbeat[i]);
    end
    if (abort_after == 0) begin
      csum_q.push_back(exp_csum >= 0 ? 16'(exp_csum) : ref_csum(seed, n, lkeep));
      len_q.push_back(n);
    end
    for (int i = 0; i < n; i++) begin
      if (abort_after != 0 && i == abort_after) begin
        in_valid = 1'b0;
        in_last  = 1'b0;
        wr_rst   = 1'b1;
        repeat (2) begin
          cycle();
          set_vld();
        end
        wr_rst = 1'b0;
        return;
      end
      if (rnd_gaps) begin
        gap = $urandom_range(0, 2);
        repeat (gap) begin
          in_valid = 1'b0;
          in_data  = $urandom;
          in_last  = 1'($urandom);
          cycle();
          set_vld();
        end
      end
      in_valid  = 1'b1;
      in_data   = fbeat[i];
      in_last   = (i == n - 1);
      in_keep   = (i == n - 1) ? lkeep : 4'($urandom);
      csum_init = (i == 0) ? seed : 16'($urandom);
      c = 0;
      do begin
        cycle();
        if (last_ready && stall_after != 0 && i + 1 == stall_after) stall_cnt = 5;
        set_vld();
        c++;
      end while (!last_ready && c < 200);
      if (!last_ready) begin
        tests_run++;
        tests_failed++;
        $display("FAIL handshake_timeout: in_ready got 0 required 1 within 200 cycles");
        abort_all = 1;
        in_valid  = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Monitor: per-cycle protocol checks plus the scoreboard pops.
  initial begin
    int          since;
    bit          saw_rst;
    logic        exp_ready;
    logic [15:0] ec;
    int          el;
    logic [31:0] ed;
    since   = 99;
    saw_rst = 0;
    forever begin
      @(negedge wr_clk);
      if (since < 99) since++;
      if (wr_rst) begin
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_csum_vld", 32'(csum_vld), 32'd0);
        since   = 99;
        saw_rst = 1;
      end else begin
        if (saw_rst) begin
          chk("rst_csum_out", 32'(csum_out), 32'd0);
          chk("rst_frame_beats", 32'(frame_beats), 32'd0);
          saw_rst = 0;
        end
        exp_ready = (since >= 1 && since <= 3) ? 1'b0 : wr_vld;
        chk("in_ready", 32'(in_ready), 32'(exp_ready));
        chk("wr_en", 32'(wr_en), 32'(in_valid & exp_ready));
        chk("csum_vld_timing", 32'(csum_vld), 32'(since == 3));
        if (csum_vld) begin
          if (csum_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL csum_unexpected: got csum_out 0x%0h required no result", csum_out);
          end else begin
            ec = csum_q.pop_front();
            el = len_q.pop_front();
            chk("csum_out", 32'(csum_out), 32'(ec));
            chk("frame_beats", 32'(frame_beats), 32'(el));
          end
        end
        if (wr_en) begin
          if (wr_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL wr_unexpected: got write 0x%0h required none", wr_data);
          end else begin
            ed = wr_q.pop_front();
            chk("wr_data", wr_data, ed);
          end
        end
        if (wr_en && in_last) since = 0;
      end
    end
  end

  // Stimulus.
  initial begin
    logic [3:0] ktab[4];
    int         n;
    ktab[0] = 4'h8;
    ktab[1] = 4'hC;
    ktab[2] = 4'hE;
    ktab[3] = 4'hF;
    wr_rst    = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_keep   = 4'h0;
    in_data   = 32'h0;
    csum_init = 16'h0;
    wr_vld    = 1'b1;
    repeat (3) cycle();
    wr_rst = 1'b0;

    fbeat[0] = 32'h45000073;
    drive_frame(16'h0000, 1, 4'hF, 0, 0, 'hBA8C);
    fbeat[0] = 32'hFFFFFFFF;
    fbeat[1] = 32'h00000001;
    drive_frame(16'h0000, 2, 4'hF, 0, 0, 'hFFFE);
    fbeat[0] = 32'hFFFF0000;
    drive_frame(16'h0000, 1, 4'hF, 0, 0, 'hFFFF);
    fbeat[0] = 32'h12345678;
    drive_frame(16'h0011, 1, 4'hC, 0, 0, 'hEDBA);

    // The same frame is sent stalled and then unstalled. Both results must
    // match the model.
    fbeat[0] = 32'h01020304;
    fbeat[1] = 32'hA0B0C0D0;
    fbeat[2] = 32'h0000FF00;
    drive_frame(16'h1111, 3, 4'hE, 1, 0, -1);
    drive_frame(16'h1111, 3, 4'hE, 0, 0, -1);

    // A frame is aborted by reset after two beats, then a fresh frame is sent.
    for (int i = 0; i < 4; i++) fbeat[i] = $urandom;
    drive_frame(16'($urandom), 4, 4'hF, 0, 2, -1);
    fbeat[0] = 32'h45000073;
    drive_frame(16'h0000, 1, 4'hF, 0, 0, 'hBA8C);

    rnd_vld  = 1;
    rnd_gaps = 1;
    repeat (40) begin
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) fbeat[i] = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
      drive_frame(16'($urandom), n, ktab[$urandom_range(0, 3)],
                  ($urandom_range(0, 4) == 0) ? $urandom_range(1, n) : 0, 0, -1);
    end

    in_valid = 1'b0;
    repeat (10) cycle();
    chk("csum_q_drained", 32'(csum_q.size()), 32'd0);
    chk("wr_q_drained", 32'(wr_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
